forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the ID-stage operand forwarding logic.
- Resolves N read ports against M in-flight pipeline stages, with youngest-first priority.
- Adds a per-register scoreboard of outstanding long-latency writes (loads, mul/div) and generates the ID stall.
- Sits between the register file read and ID/EX; also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 4, register index width (RV32E = 16 regs).
- NUM_RD_PORTS, 2, number of operand read ports.
- NUM_STAGES, 4, forwarding source stages; index 0 = youngest (EX).
- CNT_W, 2, width of per-register outstanding-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rs_addr  in  NUM_RD_PORTS*REG_ADDR_W  source register per port.
- rs_used  in  NUM_RD_PORTS  port actually consumed by the instruction in ID.
- rf_data  in  NUM_RD_PORTS*XLEN  register-file read data per port.
- stg_we  in  NUM_STAGES  stage holds a register-writing instruction.
- stg_rd  in  NUM_STAGES*REG_ADDR_W  destination register per stage.
- stg_data_valid  in  NUM_STAGES  stage result already computed (ALU or PC+4).
- stg_data  in  NUM_STAGES*XLEN  result per stage.
- issue_valid  in  1  instruction in ID wants to advance.
- issue_we  in  1  issuing instruction writes rd.
- issue_rd  in  REG_ADDR_W  issuing destination register.
- issue_long  in  1  result is produced by a long-latency unit, not by the stage data.
- flush  in  1  kill the ID instruction this cycle.
- cmpl_valid  in  1  long-latency result writes back this cycle.
- cmpl_rd  in  REG_ADDR_W  completion destination.
- cmpl_data  in  XLEN  completion data.
- rs_data  out  NUM_RD_PORTS*XLEN  resolved operand per port.
- rs_forwarded  out  NUM_RD_PORTS  operand came from a bypass, not rf_data.
- stall  out  1  hold IF/ID and inject a bubble into EX.
- stall_count  out  32  saturating count of stall cycles.
- sb_underflow  out  1  sticky error flag.

Behaviour:
- Reset:
  - All scoreboard counters 0; stall_count 0; sb_underflow 0.
  - Combinational outputs follow their inputs (stall = 0 while the counters are 0 and no stage matches).
- Port resolution (combinational, per port p):
  - rs_addr == 0: rs_data = 0, rs_forwarded = 1, no hazard.
  - Otherwise scan stages 0..NUM_STAGES-1 and take the first i with stg_we[i] && stg_rd[i] == rs_addr.
    - If stg_data_valid[i]: rs_data = stg_data[i], rs_forwarded = 1.
    - Else: hazard[p] = 1, rs_data = rf_data, rs_forwarded = 0. Older stages are not consulted.
  - No stage match and cmpl_valid && cmpl_rd == rs_addr: rs_data = cmpl_data, rs_forwarded = 1.
  - No match at all: rs_data = rf_data, rs_forwarded = 0. If the scoreboard counter for rs_addr != 0, hazard[p] = 1.
    - Exception: the completion bypass in the same cycle satisfies a pending register; no hazard.
- Stall:
  - stall = issue_valid && (OR over p of rs_used[p] && hazard[p] || (issue_we && issue_long && cnt[issue_rd] == max)).
  - flush does not gate stall.
- Scoreboard (sequential):
  - issue_fire = issue_valid && !stall && !flush.
  - inc = issue_fire && issue_we && issue_long && issue_rd != 0.
  - dec = cmpl_valid && cmpl_rd != 0.
  - inc and dec on the same register in one cycle: counter unchanged.
  - On different registers: both updates apply in that cycle.
  - dec on a counter already at 0: counter stays 0 and sb_underflow is set (sticky until rst).
  - Register 0 is never tracked.
- stall_count: increments each cycle stall = 1 and saturates at 0xFFFF_FFFF.
- Reset mid-operation: all state clears in the next cycle; completions that arrive afterwards underflow and set the flag. Software must drain long-latency units before asserting rst.

Decomposition:
- Shared package fwd_pkg:
  - STAGE_EX = 0, STAGE_MEMPREP = 1, STAGE_MEMEX = 2, STAGE_WB = 3.
  - Default parameter values.
  - typedef reg_idx_t (logic [REG_ADDR_W-1:0]).
- Sub-module reg_scoreboard: the counter array, increment/decrement/underflow logic, and the cnt read ports for rs_addr and issue_rd.
- The top level holds the port-resolution generate loop, the stall logic and stall_count.

Test Plan:
1. Reset then idle: rs_addr = {3,5}, rf_data = {0x11, 0x22} -> rs_data = {0x11, 0x22}, rs_forwarded = 00, stall = 0, stall_count = 0.
2. Priority: stage0 and stage2 both write x3 (valid, data 0xA and 0xC), port0 reads x3 -> rs_data[0] = 0xA, forwarded = 1. Clear stage0 -> 0xC.
3. Load-use: stage0 writes x5 with stg_data_valid = 0, port1 reads x5 with rs_used = 1 -> stall = 1, stall_count increments each cycle. With rs_used[1] = 0 -> stall = 0.
4. Long op: issue x7 long (fires); the next instruction reads x7 -> stall held until cmpl_valid with cmpl_rd = 7 and cmpl_data = 0xBEEF. In that cycle rs_data = 0xBEEF, stall = 0, and the counter returns to 0.
5. Saturation and simultaneity:
   - Three long issues to x4 (CNT_W = 2) -> the fourth stalls.
   - Issue long x4 together with a completion to x4 -> count unchanged.
   - Issue with flush = 1 -> no increment.
6. x0 and underflow: a port reads x0 while a stage writes x0 -> rs_data = 0, forwarded = 1. cmpl_valid to x9 with count 0 -> sb_underflow = 1 and stays 1 until rst.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and types for the ID-stage operand forwarding and scoreboard block.
package fwd_pkg;

   localparam int unsigned DEF_XLEN         = 32;
   localparam int unsigned DEF_REG_ADDR_W   = 4;
   localparam int unsigned DEF_NUM_RD_PORTS = 2;
   localparam int unsigned DEF_NUM_STAGES   = 4;
   localparam int unsigned DEF_CNT_W        = 2;

   localparam int unsigned STAGE_EX      = 0;
   localparam int unsigned STAGE_MEMPREP = 1;
   localparam int unsigned STAGE_MEMEX   = 2;
   localparam int unsigned STAGE_WB      = 3;

   typedef logic [DEF_REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// Bundle of operand, stage, issue and completion signals between the pipeline and the
// forwarding scoreboard.
interface forwarding_scoreboard_if import fwd_pkg::*; #(
   parameter int unsigned XLEN         = DEF_XLEN,
   parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int unsigned NUM_RD_PORTS = DEF_NUM_RD_PORTS,
   parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES
);
   logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rs_addr;
   logic [NUM_RD_PORTS-1:0]            rs_used;
   logic [NUM_RD_PORTS*XLEN-1:0]       rf_data;
   logic [NUM_STAGES-1:0]              stg_we;
   logic [NUM_STAGES*REG_ADDR_W-1:0]   stg_rd;
   logic [NUM_STAGES-1:0]              stg_data_valid;
   logic [NUM_STAGES*XLEN-1:0]         stg_data;
   logic                               issue_valid;
   logic                               issue_we;
   logic [REG_ADDR_W-1:0]              issue_rd;
   logic                               issue_long;
   logic                               flush;
   logic                               cmpl_valid;
   logic [REG_ADDR_W-1:0]              cmpl_rd;
   logic [XLEN-1:0]                    cmpl_data;
   logic [NUM_RD_PORTS*XLEN-1:0]       rs_data;
   logic [NUM_RD_PORTS-1:0]            rs_forwarded;
   logic                               stall;
   logic [31:0]                        stall_count;
   logic                               sb_underflow;

   modport master (
      output rs_addr, rs_used, rf_data, stg_we, stg_rd, stg_data_valid, stg_data,
             issue_valid, issue_we, issue_rd, issue_long, flush, cmpl_valid, cmpl_rd,
             cmpl_data,
      input  rs_data, rs_forwarded, stall, stall_count, sb_underflow
   );

   modport slave (
      input  rs_addr, rs_used, rf_data, stg_we, stg_rd, stg_data_valid, stg_data,
             issue_valid, issue_we, issue_rd, issue_long, flush, cmpl_valid, cmpl_rd,
             cmpl_data,
      output rs_data, rs_forwarded, stall, stall_count, sb_underflow
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register count of outstanding long-latency writes, with sticky underflow detection.
module reg_scoreboard import fwd_pkg::*; #(
   parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int unsigned NUM_RD_PORTS = DEF_NUM_RD_PORTS,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               inc,
   input  logic [REG_ADDR_W-1:0]              inc_rd,
   input  logic                               dec,
   input  logic [REG_ADDR_W-1:0]              dec_rd,
   input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rs_addr,
   output logic [NUM_RD_PORTS*CNT_W-1:0]      rs_cnt,
   input  logic [REG_ADDR_W-1:0]              issue_rd,
   output logic [CNT_W-1:0]                   issue_cnt,
   output logic                               underflow
);
   localparam int unsigned NREGS = 1 << REG_ADDR_W;

   logic [CNT_W-1:0] cnt_q [NREGS];
   logic [CNT_W-1:0] cnt_d [NREGS];
   logic             underflow_q, underflow_d;
   logic             same_reg;

   assign same_reg = inc && dec && (inc_rd == dec_rd);

   always_comb begin
      cnt_d[0]    = '0;
      underflow_d = underflow_q;
      for (int r = 1; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!same_reg) begin
            if (inc && inc_rd == REG_ADDR_W'(r)) begin
               cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && dec_rd == REG_ADDR_W'(r)) begin
               if (cnt_q[r] == '0) underflow_d = 1'b1;
               else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
         underflow_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
         underflow_q <= underflow_d;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      assign rs_cnt[p*CNT_W +: CNT_W] = cnt_q[rs_addr[p*REG_ADDR_W +: REG_ADDR_W]];
   end

   assign issue_cnt = cnt_q[issue_rd];
   assign underflow = underflow_q;

endmodule

// File: rtl/forwarding_scoreboard.sv
// ID-stage operand forwarding with youngest-first stage priority, long-latency scoreboard,
// stall generation and a saturating stall-cycle counter.
module forwarding_scoreboard import fwd_pkg::*; #(
   parameter int unsigned XLEN         = DEF_XLEN,
   parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int unsigned NUM_RD_PORTS = DEF_NUM_RD_PORTS,
   parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input logic                    clk,
   input logic                    rst,
   forwarding_scoreboard_if.slave bus
);
   logic [NUM_RD_PORTS*CNT_W-1:0] rs_cnt;
   logic [CNT_W-1:0]              issue_cnt;
   logic [NUM_RD_PORTS-1:0]       hazard;
   logic                          stall;
   logic                          inc, dec;
   logic [31:0]                   stall_count_q;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
      logic                  fwd, haz, found;

      assign addr = bus.rs_addr[p*REG_ADDR_W +: REG_ADDR_W];

      always_comb begin
         data  = bus.rf_data[p*XLEN +: XLEN];
         fwd   = 1'b0;
         haz   = 1'b0;
         found = 1'b0;
         if (addr == '0) begin
            data = '0;
            fwd  = 1'b1;
         end else begin
            // First matching stage wins; a not-yet-computed result blocks older stages.
            for (int i = 0; i < NUM_STAGES; i++) begin
               if (!found && bus.stg_we[i] && bus.stg_rd[i*REG_ADDR_W +: REG_ADDR_W] == addr) begin
                  found = 1'b1;
                  if (bus.stg_data_valid[i]) begin
                     data = bus.stg_data[i*XLEN +: XLEN];
                     fwd  = 1'b1;
                  end else begin
                     haz = 1'b1;
                  end
               end
            end
            if (!found) begin
               if (bus.cmpl_valid && bus.cmpl_rd == addr) begin
                  data = bus.cmpl_data;
                  fwd  = 1'b1;
               end else if (rs_cnt[p*CNT_W +: CNT_W] != '0) begin
                  haz = 1'b1;
               end
            end
         end
      end

      assign bus.rs_data[p*XLEN +: XLEN] = data;
      assign bus.rs_forwarded[p]         = fwd;
      assign hazard[p]                   = haz;
   end

   assign stall = bus.issue_valid &&
                  ((|(bus.rs_used & hazard)) ||
                   (bus.issue_we && bus.issue_long && issue_cnt == '1));

   assign inc = bus.issue_valid && !stall && !bus.flush && bus.issue_we && bus.issue_long &&
                (bus.issue_rd != '0);
   assign dec = bus.cmpl_valid && (bus.cmpl_rd != '0);

   reg_scoreboard #(
      .REG_ADDR_W  (REG_ADDR_W),
      .NUM_RD_PORTS(NUM_RD_PORTS),
      .CNT_W       (CNT_W)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .inc_rd   (bus.issue_rd),
      .dec      (dec),
      .dec_rd   (bus.cmpl_rd),
      .rs_addr  (bus.rs_addr),
      .rs_cnt   (rs_cnt),
      .issue_rd (bus.issue_rd),
      .issue_cnt(issue_cnt),
      .underflow(bus.sb_underflow)
   );

   always_ff @(posedge clk) begin
      if (rst)                               stall_count_q <= '0;
      else if (stall && stall_count_q != '1) stall_count_q <= stall_count_q + 32'd1;
   end

   assign bus.stall       = stall;
   assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed-vector bench for forwarding_scoreboard: forwarding priority, hazards, scoreboard
// saturation/simultaneity, x0 handling and sticky underflow.
module tb_forwarding_scoreboard;
   import fwd_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   forwarding_scoreboard_if bus ();

   forwarding_scoreboard dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stage(input int i, input logic we, input logic [3:0] rd,
                            input logic vld, input logic [31:0] data);
      bus.stg_we[i]             = we;
      bus.stg_rd[i*4 +: 4]      = rd;
      bus.stg_data_valid[i]     = vld;
      bus.stg_data[i*32 +: 32]  = data;
   endtask

   task automatic idle();
      bus.rs_addr        = {4'd5, 4'd3};
      bus.rs_used        = 2'b00;
      bus.rf_data        = {32'h22, 32'h11};
      bus.stg_we         = '0;
      bus.stg_rd         = '0;
      bus.stg_data_valid = '0;
      bus.stg_data       = '0;
      bus.issue_valid    = 1'b0;
      bus.issue_we       = 1'b0;
      bus.issue_rd       = '0;
      bus.issue_long     = 1'b0;
      bus.flush          = 1'b0;
      bus.cmpl_valid     = 1'b0;
      bus.cmpl_rd        = '0;
      bus.cmpl_data      = '0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // 1. reset and idle
      check("idle_data0", bus.rs_data[31:0], 32'h11);
      check("idle_data1", bus.rs_data[63:32], 32'h22);
      check("idle_fwd", 32'(bus.rs_forwarded), 32'h0);
      check("idle_stall", 32'(bus.stall), 32'h0);
      check("idle_cnt", bus.stall_count, 32'h0);
      check("idle_uf", 32'(bus.sb_underflow), 32'h0);

      // 2. youngest stage wins
      set_stage(STAGE_EX, 1'b1, 4'd3, 1'b1, 32'hA);
      set_stage(STAGE_MEMEX, 1'b1, 4'd3, 1'b1, 32'hC);
      #1;
      check("prio_ex", bus.rs_data[31:0], 32'hA);
      check("prio_fwd", 32'(bus.rs_forwarded[0]), 32'h1);
      set_stage(STAGE_EX, 1'b0, 4'd3, 1'b1, 32'hA);
      #1;
      check("prio_memex", bus.rs_data[31:0], 32'hC);

      // 3. load-use hazard
      idle();
      set_stage(STAGE_EX, 1'b1, 4'd5, 1'b0, 32'h55);
      set_stage(STAGE_WB, 1'b1, 4'd5, 1'b1, 32'h77);
      bus.rs_used     = 2'b10;
      bus.issue_valid = 1'b1;
      #1;
      check("lu_stall", 32'(bus.stall), 32'h1);
      check("lu_data1", bus.rs_data[63:32], 32'h22);
      check("lu_fwd1", 32'(bus.rs_forwarded[1]), 32'h0);
      tick();
      tick();
      check("lu_cnt2", bus.stall_count, 32'd2);
      bus.rs_used = 2'b00;
      #1;
      check("lu_unused", 32'(bus.stall), 32'h0);
      tick();
      check("lu_cnt_hold", bus.stall_count, 32'd2);

      // 4. long op on x7, resolved by completion bypass
      idle();
      bus.issue_valid = 1'b1;
      bus.issue_we    = 1'b1;
      bus.issue_long  = 1'b1;
      bus.issue_rd    = 4'd7;
      #1;
      check("long_issue", 32'(bus.stall), 32'h0);
      tick();
      bus.issue_we   = 1'b0;
      bus.issue_long = 1'b0;
      bus.rs_addr    = {4'd5, 4'd7};
      bus.rs_used    = 2'b01;
      #1;
      check("long_wait", 32'(bus.stall), 32'h1);
      check("long_wait_fwd", 32'(bus.rs_forwarded[0]), 32'h0);
      tick();
      check("long_wait2", 32'(bus.stall), 32'h1);
      bus.cmpl_valid = 1'b1;
      bus.cmpl_rd    = 4'd7;
      bus.cmpl_data  = 32'hBEEF;
      #1;
      check("cmpl_data", bus.rs_data[31:0], 32'hBEEF);
      check("cmpl_fwd", 32'(bus.rs_forwarded[0]), 32'h1);
      check("cmpl_stall", 32'(bus.stall), 32'h0);
      tick();
      bus.cmpl_valid = 1'b0;
      #1;
      check("drained_stall", 32'(bus.stall), 32'h0);
      check("drained_data", bus.rs_data[31:0], 32'h11);
      check("long_cnt", bus.stall_count, 32'd3);

      // 5. saturation, simultaneous inc/dec, flush
      idle();
      bus.issue_valid = 1'b1;
      bus.issue_we    = 1'b1;
      bus.issue_long  = 1'b1;
      bus.issue_rd    = 4'd4;
      for (int k = 0; k < 3; k++) tick();
      check("sat_stall", 32'(bus.stall), 32'h1);
      tick();
      check("sat_cnt", bus.stall_count, 32'd4);
      bus.issue_valid = 1'b0;
      bus.cmpl_valid  = 1'b1;
      bus.cmpl_rd     = 4'd4;
      tick();
      bus.issue_valid = 1'b1;
      #1;
      check("simul_nostall", 32'(bus.stall), 32'h0);
      tick();
      bus.cmpl_valid = 1'b0;
      #1;
      check("simul_two", 32'(bus.stall), 32'h0);
      tick();
      check("simul_full", 32'(bus.stall), 32'h1);
      bus.issue_valid = 1'b0;
      bus.cmpl_valid  = 1'b1;
      tick();
      bus.cmpl_valid  = 1'b0;
      bus.issue_valid = 1'b1;
      bus.flush       = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      check("flush_noinc", 32'(bus.stall), 32'h0);
      bus.issue_valid = 1'b0;
      bus.cmpl_valid  = 1'b1;
      tick();
      tick();
      bus.cmpl_valid = 1'b0;
      #1;
      check("drain_uf", 32'(bus.sb_underflow), 32'h0);
      check("sat_cnt_end", bus.stall_count, 32'd4);

      // 6. x0 and sticky underflow
      idle();
      set_stage(STAGE_EX, 1'b1, 4'd0, 1'b1, 32'hDEAD);
      bus.rs_addr = {4'd5, 4'd0};
      #1;
      check("x0_data", bus.rs_data[31:0], 32'h0);
      check("x0_fwd", 32'(bus.rs_forwarded[0]), 32'h1);
      idle();
      bus.cmpl_valid = 1'b1;
      bus.cmpl_rd    = 4'd9;
      tick();
      bus.cmpl_valid = 1'b0;
      check("uf_set", 32'(bus.sb_underflow), 32'h1);
      tick();
      tick();
      check("uf_sticky", 32'(bus.sb_underflow), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("uf_rst", 32'(bus.sb_underflow), 32'h0);
      check("cnt_rst", bus.stall_count, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
